// File: rtl/gfx_pkg.sv
// gfx_pkg: shared constants and types for the gfx bank scheduler.
// Requester indices, bank FSM encoding, bank-select width, RR helper.
package gfx_pkg;

  localparam int N_REQ      = 4;
  localparam int BANK_SEL_W = 2;

  localparam int REQ_SPRITE = 0;
  localparam int REQ_BG0    = 1;
  localparam int REQ_BG1    = 2;
  localparam int REQ_OV     = 3;

  typedef enum logic {
    BANK_IDLE = 1'b0,
    BANK_BUSY = 1'b1
  } bank_state_e;

  typedef logic [BANK_SEL_W-1:0] req_idx_t;

  typedef struct packed {
    logic     hit;
    req_idx_t idx;
  } grant_t;

  // first candidate at or above ptr, wrapping; lowest offset wins
  function automatic grant_t rr_pick(
    input logic [N_REQ-1:0] cand,
    input req_idx_t         ptr
  );
    grant_t   g;
    req_idx_t r;
    g = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      r = ptr + req_idx_t'(k);
      if (cand[r]) begin
        g.hit = 1'b1;
        g.idx = r;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/gfx_bank_scheduler_if.sv
// gfx_bank_scheduler_if: requester and bank-side signals of the scheduler.
// slave = scheduler view, master = requesters plus bank memories.
interface gfx_bank_scheduler_if #(
  parameter int BITS              = 16,
  parameter int BANK_ADDRESS_BITS = 14
);

  logic [4*(BANK_ADDRESS_BITS+2)-1:0] REQ_ADDR;
  logic [3:0]                         REQ_VALID;
  logic [3:0]                         REQ_READY;
  logic [4*BITS-1:0]                  REQ_DATA;
  logic [4*BANK_ADDRESS_BITS-1:0]     B_ADDR;
  logic [3:0]                         B_VALID;
  logic [4*BITS-1:0]                  B_DIN;
  logic [3:0]                         B_READY;

  modport slave (
    input  REQ_ADDR, REQ_VALID, B_DIN, B_READY,
    output REQ_READY, REQ_DATA, B_ADDR, B_VALID
  );

  modport master (
    output REQ_ADDR, REQ_VALID, B_DIN, B_READY,
    input  REQ_READY, REQ_DATA, B_ADDR, B_VALID
  );

endinterface

// File: rtl/gfx_bank_port.sv
// gfx_bank_port: one bank's IDLE/BUSY FSM, RR pointer and address latch.
// GFX_SCHED_SPRITE_PRIO_EN: sprite requester overrides the pointer.
module gfx_bank_port
  import gfx_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         cand,
  input  logic [N_REQ-1:0][AW-1:0] addr_in,
  input  logic                     b_ready,
  output logic                     b_valid,
  output logic [AW-1:0]            b_addr,
  output logic                     done,
  output req_idx_t                 owner
);

  bank_state_e state;
  req_idx_t    ptr;
  grant_t      pick;

  // choose the winner among requesters pending on this bank
  always_comb begin
    pick = rr_pick(cand, ptr);
`ifdef GFX_SCHED_SPRITE_PRIO_EN
    if (cand[REQ_SPRITE]) begin
      pick.hit = 1'b1;
      pick.idx = req_idx_t'(REQ_SPRITE);
    end
`endif
  end

  assign done = (state == BANK_BUSY) && b_ready;

  // grant in IDLE, hold the bank request in BUSY until b_ready
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= BANK_IDLE;
      ptr     <= '0;
      owner   <= '0;
      b_valid <= 1'b0;
      b_addr  <= '0;
    end else begin
      unique case (state)
        BANK_IDLE: begin
          if (pick.hit) begin
            state   <= BANK_BUSY;
            owner   <= pick.idx;
            b_addr  <= addr_in[pick.idx];
            b_valid <= 1'b1;
`ifdef GFX_SCHED_SPRITE_PRIO_EN
            if (pick.idx != req_idx_t'(REQ_SPRITE))
              ptr <= pick.idx + 2'd1;
`else
            ptr <= pick.idx + 2'd1;
`endif
          end
        end
        BANK_BUSY: begin
          if (b_ready) begin
            state   <= BANK_IDLE;
            b_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/gfx_bank_scheduler.sv
// gfx_bank_scheduler: routes four requesters onto four independent banks.
// GFX_SCHED_SPRITE_PRIO_EN (in gfx_bank_port) gives sprite priority.
module gfx_bank_scheduler
  import gfx_pkg::*;
#(
  parameter int BITS              = 16,
  parameter int BANK_ADDRESS_BITS = 14
) (
  input logic                  CLK,
  input logic                  RST,
  gfx_bank_scheduler_if.slave  bus
);

  localparam int AW = BANK_ADDRESS_BITS;
  localparam int RW = AW + BANK_SEL_W;

  logic [N_REQ-1:0][AW-1:0]         req_lo;
  logic [N_REQ-1:0][BANK_SEL_W-1:0] req_bank;
  logic [N_REQ-1:0][N_REQ-1:0]      cand;
  logic [N_REQ-1:0]                 done;
  logic [N_REQ-1:0]                 b_valid;
  logic [N_REQ-1:0][AW-1:0]         b_addr;
  req_idx_t                         owner [N_REQ];
  logic [N_REQ-1:0][BITS-1:0]       b_din;
  logic [N_REQ-1:0]                 ready_q;
  logic [N_REQ-1:0]                 ready_d;
  logic [N_REQ-1:0][BITS-1:0]       data_q;
  logic [N_REQ-1:0][BITS-1:0]       data_d;

  assign b_din = bus.B_DIN;

  // split addresses; a requester is a candidate only while not pulsing
  always_comb begin
    req_lo   = '0;
    req_bank = '0;
    cand     = '0;
    for (int r = 0; r < N_REQ; r++) begin
      req_lo[r]   = bus.REQ_ADDR[r*RW +: AW];
      req_bank[r] = bus.REQ_ADDR[r*RW+AW +: BANK_SEL_W];
    end
    for (int b = 0; b < N_REQ; b++)
      for (int r = 0; r < N_REQ; r++)
        cand[b][r] = bus.REQ_VALID[r] && !ready_q[r]
                     && (req_bank[r] == req_idx_t'(b));
  end

  for (genvar b = 0; b < N_REQ; b++) begin : g_bank
    gfx_bank_port #(
      .AW(AW)
    ) u_port (
      .CLK     (CLK),
      .RST     (RST),
      .cand    (cand[b]),
      .addr_in (req_lo),
      .b_ready (bus.B_READY[b]),
      .b_valid (b_valid[b]),
      .b_addr  (b_addr[b]),
      .done    (done[b]),
      .owner   (owner[b])
    );
  end

  // steer bank completions back to their owners
  always_comb begin
    ready_d = '0;
    data_d  = data_q;
    for (int b = N_REQ - 1; b >= 0; b--) begin
      if (done[b]) begin
        ready_d[owner[b]] = 1'b1;
        data_d[owner[b]]  = b_din[b];
      end
    end
  end

  // one-cycle ready pulse; data holds between completions
  always_ff @(posedge CLK) begin
    if (RST) begin
      ready_q <= '0;
      data_q  <= '0;
    end else begin
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign bus.REQ_READY = ready_q;
  assign bus.REQ_DATA  = data_q;
  assign bus.B_VALID   = b_valid;
  assign bus.B_ADDR    = b_addr;

endmodule

// File: tb/tb_gfx_bank_scheduler.sv
// tb_gfx_bank_scheduler: scoreboard bench with a rule-level bank model.
// Honours GFX_SCHED_SPRITE_PRIO_EN in its reference model.
module tb_gfx_bank_scheduler;

  localparam int BITS = 16;
  localparam int AW   = 14;
  localparam int RW   = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  gfx_bank_scheduler_if #(.BITS(BITS), .BANK_ADDRESS_BITS(AW)) bus ();

  gfx_bank_scheduler #(
    .BITS(BITS),
    .BANK_ADDRESS_BITS(AW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic [3:0]      v;
  logic [RW-1:0]   a   [4];
  logic [3:0]      br;
  logic [BITS-1:0] din [4];
  bit              act [4];

  bit         auto_en  = 0;
  logic [3:0] en_mask  = 4'hF;
  bit         fix_bank = 0;
  logic [1:0] fbank    = 2'd0;
  bit         rnd_low  = 0;
  int         issue_p  = 0;
  int         rdy_p    = 0;
  int         drop_p   = 0;
  int         chg_p    = 0;

  // ---------------- reference model ----------------
  bit              m_busy [4];
  int              m_own  [4];
  logic [AW-1:0]   m_addr [4];
  int              m_ptr  [4];
  bit              m_rdy  [4];
  logic [BITS-1:0] m_data [4];
  logic [BITS-1:0] expq   [4][$];

  function automatic int pct();
    return int'($urandom_range(0, 99));
  endfunction

  function automatic bit owned(int r);
    for (int b = 0; b < 4; b++)
      if (m_busy[b] && m_own[b] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit elig(int r, int b);
    return bus.REQ_VALID[r] && !m_rdy[r]
           && (bus.REQ_ADDR[r*RW+AW +: 2] == 2'(b));
  endfunction

  task automatic apply();
    bus.REQ_VALID = v;
    bus.B_READY   = br;
    for (int r = 0; r < 4; r++) begin
      bus.REQ_ADDR[r*RW +: RW] = a[r];
      bus.B_DIN[r*BITS +: BITS] = din[r];
    end
  endtask

  task automatic drive();
    for (int b = 0; b < 4; b++) begin
      br[b]  = (pct() < rdy_p);
      din[b] = BITS'($urandom);
    end
    if (auto_en) begin
      for (int r = 0; r < 4; r++) begin
        if (bus.REQ_READY[r]) begin
          act[r] = 0;
          v[r]   = 1'b0;
        end
        if (!en_mask[r]) continue;
        if (!act[r]) begin
          if (pct() < issue_p) begin
            act[r] = 1;
            v[r]   = 1'b1;
            a[r][RW-1:AW] = fix_bank ? fbank : 2'($urandom);
            a[r][AW-1:0]  = rnd_low ? AW'($urandom)
                                    : AW'(16'h0100 * r + 5);
          end
        end else begin
          if (v[r] && owned(r) && pct() < drop_p) v[r] = 1'b0;
          if (pct() < chg_p) a[r][AW-1:0] = AW'($urandom);
        end
      end
    end
    apply();
  endtask

  task automatic step();
    @(negedge CLK);
    drive();
  endtask

  task automatic drain();
    auto_en = 1; issue_p = 0; rdy_p = 100; drop_p = 0; chg_p = 0;
    repeat (20) step();
    auto_en = 0;
    v = '0;
    for (int r = 0; r < 4; r++) act[r] = 0;
    apply();
  endtask

  // model: sample inputs at each rising edge and apply the bank rules
  always @(posedge CLK) begin
    bit nr [4];
    int w, r, o;
    if (RST) begin
      for (int b = 0; b < 4; b++) begin
        m_busy[b] = 0; m_ptr[b] = 0; m_rdy[b] = 0;
        m_data[b] = '0; expq[b].delete();
      end
    end else begin
      for (int i = 0; i < 4; i++) nr[i] = 0;
      for (int b = 0; b < 4; b++) begin
        if (m_busy[b]) begin
          if (bus.B_READY[b]) begin
            o = m_own[b];
            nr[o] = 1;
            m_data[o] = bus.B_DIN[b*BITS +: BITS];
            expq[o].push_back(m_data[o]);
            m_busy[b] = 0;
          end
        end else begin
          w = -1;
`ifdef GFX_SCHED_SPRITE_PRIO_EN
          if (elig(0, b)) w = 0;
`endif
          for (int k = 0; k < 4; k++) begin
            r = (m_ptr[b] + k) % 4;
            if (w < 0 && elig(r, b)) w = r;
          end
          if (w >= 0) begin
            m_busy[b] = 1;
            m_own[b]  = w;
            m_addr[b] = bus.REQ_ADDR[w*RW +: AW];
`ifdef GFX_SCHED_SPRITE_PRIO_EN
            if (w != 0) m_ptr[b] = (w + 1) % 4;
`else
            m_ptr[b] = (w + 1) % 4;
`endif
          end
        end
      end
      for (int i = 0; i < 4; i++) m_rdy[i] = nr[i];
    end
  end

  // monitor: compare DUT outputs against the model between edges
  always @(negedge CLK) begin
    bit              er;
    logic [BITS-1:0] e;
    for (int r = 0; r < 4; r++) begin
      er = (expq[r].size() != 0);
      check($sformatf("req_ready[%0d]", r), 64'(bus.REQ_READY[r]), 64'(er));
      if (er) begin
        e = expq[r].pop_front();
        check($sformatf("pulse_data[%0d]", r),
              64'(bus.REQ_DATA[r*BITS +: BITS]), 64'(e));
      end
      check($sformatf("req_data[%0d]", r),
            64'(bus.REQ_DATA[r*BITS +: BITS]), 64'(m_data[r]));
    end
    for (int b = 0; b < 4; b++) begin
      check($sformatf("b_valid[%0d]", b), 64'(bus.B_VALID[b]), 64'(m_busy[b]));
      if (m_busy[b])
        check($sformatf("b_addr[%0d]", b),
              64'(bus.B_ADDR[b*AW +: AW]), 64'(m_addr[b]));
    end
  end

  // ---------------- directed and random sequences ----------------
  initial begin
    logic [BITS-1:0] d;
    logic [AW-1:0]   ba;
    int hold, pulses, prev_r, r_obs, pend;
    int cnt [4];
    bit prev_bv;

    v = '0; br = '0;
    for (int r = 0; r < 4; r++) begin
      a[r] = '0; din[r] = '0; act[r] = 0;
    end
    apply();
    RST = 1'b1;
    step();
    step();
    check("rst_b_valid",   64'(bus.B_VALID),   64'd0);
    check("rst_b_addr",    64'(bus.B_ADDR),    64'd0);
    check("rst_req_ready", 64'(bus.REQ_READY), 64'd0);
    check("rst_req_data",  64'(bus.REQ_DATA),  64'd0);
    RST = 1'b0;

    // single request, bank always ready
    rdy_p = 100;
    step();
    v[1] = 1'b1; a[1] = 16'h4123; apply();
    step();
    check("s1_b_valid", 64'(bus.B_VALID[1]), 64'd1);
    check("s1_b_addr",  64'(bus.B_ADDR[AW +: AW]), 64'h0123);
    check("s1_early_ready", 64'(bus.REQ_READY[1]), 64'd0);
    d = din[1];
    step();
    check("s1_ready", 64'(bus.REQ_READY[1]), 64'd1);
    check("s1_data",  64'(bus.REQ_DATA[BITS +: BITS]), 64'(d));
    v[1] = 1'b0; apply();
    drain();

    // two banks in parallel
    rdy_p = 100;
    step();
    v[0] = 1'b1; a[0] = 16'h8022;
    v[3] = 1'b1; a[3] = 16'hC033;
    apply();
    step();
    check("par_busy", 64'(bus.B_VALID[3:2]), 64'd3);
    step();
    check("par_ready", 64'({bus.REQ_READY[3], bus.REQ_READY[0]}), 64'd3);
    v = '0; apply();
    drain();

    // slow bank: request held for five cycles
    rdy_p = 0;
    step();
    v[2] = 1'b1; a[2] = 16'h0456; apply();
    hold = 0; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.B_VALID[0] && bus.B_ADDR[AW-1:0] == 14'h0456) hold++;
      pulses += int'(bus.REQ_READY[2]);
    end
    br[0] = 1'b1; apply();
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(bus.REQ_READY[2]);
      if (bus.REQ_READY[2]) begin v[2] = 1'b0; apply(); end
    end
    check("slow_hold",   64'(hold),   64'd5);
    check("slow_pulses", 64'(pulses), 64'd1);
    drain();

    // reset while bank 1 is busy
    rdy_p = 0;
    step();
    v[1] = 1'b1; a[1] = 16'h4077; apply();
    step();
    step();
    check("rb_busy", 64'(bus.B_VALID[1]), 64'd1);
    rdy_p = 100;
    RST = 1'b1; br[1] = 1'b1; apply();
    step();
    check("rb_b_valid",   64'(bus.B_VALID),   64'd0);
    check("rb_b_addr",    64'(bus.B_ADDR),    64'd0);
    check("rb_req_ready", 64'(bus.REQ_READY), 64'd0);
    check("rb_req_data",  64'(bus.REQ_DATA),  64'd0);
    v[1] = 1'b0; apply();
    step();
    RST = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(bus.REQ_READY[1]);
    end
    check("rb_no_ready", 64'(pulses), 64'd0);
    drain();

    // all four requesters hammering bank 0
    auto_en = 1; en_mask = 4'hF; fix_bank = 1; fbank = 2'd0;
    rnd_low = 0; issue_p = 100; rdy_p = 100; drop_p = 0; chg_p = 0;
    for (int r = 0; r < 4; r++) cnt[r] = 0;
    prev_bv = bus.B_VALID[0]; prev_r = -1;
    repeat (48) begin
      step();
      if (bus.B_VALID[0] && !prev_bv) begin
        ba = bus.B_ADDR[AW-1:0];
        r_obs = int'(ba[AW-1:8]);
        if (prev_r >= 0) check("rr_order", 64'(r_obs), 64'((prev_r + 1) % 4));
        if (r_obs < 4) cnt[r_obs]++;
        prev_r = r_obs;
      end
      prev_bv = bus.B_VALID[0];
    end
    for (int r = 0; r < 4; r++)
      check($sformatf("rr_served[%0d]", r), 64'(cnt[r] >= 5), 64'd1);
    drain();

    // sprite against bg1 on bank 1
    auto_en = 1; en_mask = 4'b0101; fix_bank = 1; fbank = 2'd1;
    rnd_low = 0; issue_p = 100; rdy_p = 100;
    for (int r = 0; r < 4; r++) cnt[r] = 0;
    prev_bv = bus.B_VALID[1]; prev_r = -1;
    repeat (40) begin
      step();
      if (bus.B_VALID[1] && !prev_bv) begin
        ba = bus.B_ADDR[AW +: AW];
        r_obs = int'(ba[AW-1:8]);
`ifndef GFX_SCHED_SPRITE_PRIO_EN
        if (prev_r >= 0) check("alt_order", 64'(r_obs != prev_r), 64'd1);
`endif
        if (r_obs < 4) cnt[r_obs]++;
        prev_r = r_obs;
      end
      prev_bv = bus.B_VALID[1];
    end
    check("alt_sprite_served", 64'(cnt[0] > 0), 64'd1);
    drain();

    // random traffic
    auto_en = 1; en_mask = 4'hF; fix_bank = 0; rnd_low = 1;
    issue_p = 50; rdy_p = 40; drop_p = 10; chg_p = 10;
    repeat (3000) step();
    drain();

    pend = 0;
    for (int r = 0; r < 4; r++) pend += expq[r].size();
    check("pending_expect", 64'(pend), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gfx_bank_scheduler.md
GFX_BANK_SCHEDULER -- requirements
Module: gfx_bank_scheduler

Interface
REQ-001 SHALL have parameter BITS, default 16, data word width.
REQ-002 SHALL have parameter BANK_ADDRESS_BITS, default 14, per-bank word address width; requester address width is BANK_ADDRESS_BITS+2.
REQ-003 SHALL have port CLK  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port REQ_ADDR  input  4*(BANK_ADDRESS_BITS+2)  read address per requester; 0=sprite, 1=bg0, 2=bg1, 3=overlay.
REQ-006 SHALL have port REQ_VALID  input  4  read request per requester.
REQ-007 SHALL have port REQ_READY  output  4  one-cycle completion pulse per requester.
REQ-008 SHALL have port REQ_DATA  output  4*BITS  returned read data per requester; valid while REQ_READY is high.
REQ-009 SHALL have port B_ADDR  output  4*BANK_ADDRESS_BITS  word address per bank.
REQ-010 SHALL have port B_VALID  output  4  read request per bank.
REQ-011 SHALL have port B_DIN  input  4*BITS  read data per bank; valid when B_READY is high.
REQ-012 SHALL have port B_READY  input  4  bank read-complete strobe.

Function
REQ-013 SHALL route each request to bank REQ_ADDR[top 2 bits] with bank address REQ_ADDR[BANK_ADDRESS_BITS-1:0].
REQ-014 SHALL run one independent FSM per bank with states IDLE and BUSY, plus a 2-bit round-robin pointer per bank.
REQ-015 SHALL, in IDLE, grant among requesters targeting that bank with REQ_VALID high and REQ_READY low, searching upward from the pointer with wrap (3 -> 0).
REQ-016 SHALL, on grant, register owner and address, enter BUSY, and set pointer to owner+1 mod 4.
REQ-017 SHALL, in BUSY, hold B_VALID high and B_ADDR stable until B_READY is sampled high.
REQ-018 SHALL, on B_READY in BUSY, latch B_DIN into the owner's REQ_DATA, pulse the owner's REQ_READY for exactly the next cycle, and return to IDLE.
REQ-019 SHALL have minimum latency of 2 cycles from REQ_VALID sampled to REQ_READY, i.e. B_READY in the first BUSY cycle.
REQ-020 SHALL permit all four banks to be busy concurrently; there is no cross-bank blocking.
REQ-021 SHALL ignore B_READY while the bank is IDLE.
REQ-022 SHALL complete a granted transaction and pulse REQ_READY even if the requester drops REQ_VALID before completion.
REQ-023 SHALL hold REQ_DATA at its last value between completions.
REQ-024 SHALL take REQ_ADDR from a requester only at grant; later address changes do not affect the in-flight access.

Reset
REQ-025 SHALL, while RST is high, force all FSMs to IDLE, all pointers to 0, and B_VALID, REQ_READY, B_ADDR and REQ_DATA to 0.
REQ-026 SHALL abandon in-flight transactions on reset, producing no REQ_READY for them and ignoring any B_READY during reset.

Configuration
REQ-027 SHALL support macro GFX_SCHED_SPRITE_PRIO_EN; when defined, requester 0 pending on a bank wins that bank's next grant regardless of the pointer, and the pointer advances only on grants to requesters 1-3.
REQ-028 SHALL, without GFX_SCHED_SPRITE_PRIO_EN, apply pure round-robin to all four requesters.

Structure
REQ-029 SHALL place requester index constants (REQ_SPRITE, REQ_BG0, REQ_BG1, REQ_OV), the bank FSM state encoding and the bank-select width in shared package gfx_pkg.
REQ-030 SHALL implement the per-bank FSM, pointer and datapath as sub-module gfx_bank_port, instantiated four times.

Verification
REQ-031 SHALL cover: single request from req1 at 0x4123 with B_READY held high -> B_VALID[1], B_ADDR=0x0123, then REQ_READY[1] 2 cycles after request with REQ_DATA = B_DIN.
REQ-032 SHALL cover: all 4 requesters continuously to bank 0 with a 1-cycle bank -> grants in order 0,1,2,3,0,...; no requester starved.
REQ-033 SHALL cover: req0 to bank 2 and req3 to bank 3 in the same cycle -> both banks BUSY in parallel and both REQ_READY pulse in the same cycle.
REQ-034 SHALL cover: B_READY delayed 5 cycles -> B_VALID and B_ADDR held constant 5 cycles; exactly one REQ_READY pulse.
REQ-035 SHALL cover: RST asserted while bank 1 is BUSY -> next cycle all outputs 0; late B_READY ignored; no REQ_READY.
REQ-036 SHALL cover, with GFX_SCHED_SPRITE_PRIO_EN: req0 re-requesting continuously against req2 -> req0 wins every grant; without the macro, req0 and req2 alternate.
